// File: rtl/keccak_pkg.sv
// ============================================================================
// Module  : keccak_pkg
// Brief   : Shared rates, mode encodings and sequencer state type for SHAKE.
// Revision: 1.0
// ============================================================================
`default_nettype none

package keccak_pkg;

    localparam int          NUM_ROUNDS_DEFAULT = 24;

    localparam logic [31:0] RATE_SHAKE128 = 32'd1344;
    localparam logic [31:0] RATE_SHAKE256 = 32'd1088;

    localparam logic [1:0]  MODE_SHAKE128 = 2'b00;
    localparam logic [1:0]  MODE_SHAKE256 = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PERMUTE      = 2'd1,
        ST_ABSORB_WAIT  = 2'd2,
        ST_SQUEEZE_WAIT = 2'd3
    } seq_state_t;

    // Reserved mode codes fall back to the SHAKE128 rate.
    function automatic logic [31:0] rate_of(input logic [1:0] mode);
        return (mode == MODE_SHAKE256) ? RATE_SHAKE256 : RATE_SHAKE128;
    endfunction

endpackage

`default_nettype wire

// File: rtl/permute_sequencer.sv
// ============================================================================
// Module  : permute_sequencer
// Brief   : Absorb/permute/squeeze control sequencer for a SHAKE datapath.
// Revision: 1.0
// ============================================================================
`default_nettype none

module permute_sequencer
    import keccak_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        input_buffer_ready,
    input  logic        last_block_in_buffer,
    input  logic        output_buffer_ready,
    input  logic [31:0] output_size,
    input  logic [1:0]  operation_mode,
    output logic        copy_control_regs_en,
    output logic        state_clear,
    output logic        absorb_enable,
    output logic        round_en,
    output logic [4:0]  round_index,
    output logic        output_buffer_we,
    output logic        input_buffer_ready_clr,
    output logic        last_block_in_buffer_clr,
    output logic        busy
);

    localparam logic [4:0] c_LAST_ROUND = 5'(NUM_ROUNDS - 1);

    seq_state_t  r_state;
    logic [4:0]  r_round;
    logic [31:0] r_remaining;
    logic        r_last;
    logic [1:0]  r_mode;

    logic [31:0] w_rate;
    logic        w_final_round;

    assign w_rate        = rate_of(r_mode);
    assign w_final_round = (r_round == c_LAST_ROUND);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_round     <= 5'd0;
            r_remaining <= 32'd0;
            r_last      <= 1'b0;
            r_mode      <= MODE_SHAKE128;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (input_buffer_ready) begin
                        r_last      <= last_block_in_buffer;
                        r_mode      <= operation_mode;
                        r_remaining <= output_size;
                        r_round     <= 5'd0;
                        r_state     <= ST_PERMUTE;
                    end
                end
                ST_PERMUTE: begin
                    if (w_final_round) begin
                        r_round <= 5'd0;
                        if (!r_last) begin
                            r_state <= ST_ABSORB_WAIT;
                        end else if (r_remaining == 32'd0) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state <= ST_SQUEEZE_WAIT;
                        end
                    end else begin
                        r_round <= r_round + 5'd1;
                    end
                end
                ST_ABSORB_WAIT: begin
                    if (input_buffer_ready) begin
                        r_last  <= last_block_in_buffer;
                        r_state <= ST_PERMUTE;
                    end
                end
                ST_SQUEEZE_WAIT: begin
                    if (output_buffer_ready) begin
                        // Clamp to zero on the final block so remaining never wraps.
                        if (r_remaining <= w_rate) begin
                            r_remaining <= 32'd0;
                            r_state     <= ST_IDLE;
                        end else begin
                            r_remaining <= r_remaining - w_rate;
                            r_state     <= ST_PERMUTE;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Strobes are gated by rst so they drop immediately, even in IDLE with a block waiting.
    always_comb begin
        copy_control_regs_en     = 1'b0;
        state_clear              = 1'b0;
        absorb_enable            = 1'b0;
        round_en                 = 1'b0;
        round_index              = 5'd0;
        output_buffer_we         = 1'b0;
        input_buffer_ready_clr   = 1'b0;
        last_block_in_buffer_clr = 1'b0;
        busy                     = 1'b0;
        if (!rst) begin
            busy = (r_state != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (input_buffer_ready) begin
                        copy_control_regs_en     = 1'b1;
                        state_clear              = 1'b1;
                        absorb_enable            = 1'b1;
                        input_buffer_ready_clr   = 1'b1;
                        last_block_in_buffer_clr = last_block_in_buffer;
                    end
                end
                ST_PERMUTE: begin
                    round_en    = 1'b1;
                    round_index = r_round;
                end
                ST_ABSORB_WAIT: begin
                    if (input_buffer_ready) begin
                        absorb_enable            = 1'b1;
                        input_buffer_ready_clr   = 1'b1;
                        last_block_in_buffer_clr = last_block_in_buffer;
                    end
                end
                ST_SQUEEZE_WAIT: begin
                    output_buffer_we = output_buffer_ready;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_permute_sequencer.sv
// ============================================================================
// Module  : tb_permute_sequencer
// Brief   : Directed self-checking bench for permute_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_permute_sequencer;

    logic        clk;
    logic        rst;
    logic        input_buffer_ready;
    logic        last_block_in_buffer;
    logic        output_buffer_ready;
    logic [31:0] output_size;
    logic [1:0]  operation_mode;
    logic        copy_control_regs_en;
    logic        state_clear;
    logic        absorb_enable;
    logic        round_en;
    logic [4:0]  round_index;
    logic        output_buffer_we;
    logic        input_buffer_ready_clr;
    logic        last_block_in_buffer_clr;
    logic        busy;

    permute_sequencer #(.NUM_ROUNDS(24)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .input_buffer_ready       (input_buffer_ready),
        .last_block_in_buffer     (last_block_in_buffer),
        .output_buffer_ready      (output_buffer_ready),
        .output_size              (output_size),
        .operation_mode           (operation_mode),
        .copy_control_regs_en     (copy_control_regs_en),
        .state_clear              (state_clear),
        .absorb_enable            (absorb_enable),
        .round_en                 (round_en),
        .round_index              (round_index),
        .output_buffer_we         (output_buffer_we),
        .input_buffer_ready_clr   (input_buffer_ready_clr),
        .last_block_in_buffer_clr (last_block_in_buffer_clr),
        .busy                     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int n_round, n_absorb, n_clear, n_we, n_lastclr, n_copy, n_cyc, idx_err;
    logic [4:0] exp_idx;
    logic       run_done;

    function automatic logic [12:0] out_vec();
        return {copy_control_regs_en, state_clear, absorb_enable, round_en, round_index,
                output_buffer_we, input_buffer_ready_clr, last_block_in_buffer_clr, busy};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_tally();
        n_round = 0; n_absorb = 0; n_clear = 0; n_we = 0;
        n_lastclr = 0; n_copy = 0; n_cyc = 0; idx_err = 0;
        exp_idx = 5'd0;
    endtask

    // Called at the falling edge, when inputs and decoded strobes are stable.
    task automatic sample_cycle();
        if (round_en) begin
            n_round++;
            if (round_index !== exp_idx) idx_err++;
            exp_idx = (exp_idx == 5'd23) ? 5'd0 : exp_idx + 5'd1;
        end
        if (absorb_enable)            n_absorb++;
        if (state_clear)              n_clear++;
        if (output_buffer_we)         n_we++;
        if (last_block_in_buffer_clr) n_lastclr++;
        if (copy_control_regs_en)     n_copy++;
        if (busy || absorb_enable)    n_cyc++;
    endtask

    // Feeds nblocks input blocks with the output buffer always ready; returns at the
    // falling edge where the sequencer is first seen back in IDLE.
    task automatic run_msg(input logic [1:0] mode, input logic [31:0] size,
                           input int nblocks, input int budget);
        int  blk;
        logic started;
        logic saw_clr;
        clear_tally();
        @(posedge clk); #1;
        blk = 0;
        started = 1'b0;
        run_done = 1'b0;
        input_buffer_ready   = 1'b1;
        last_block_in_buffer = (nblocks == 1);
        output_buffer_ready  = 1'b1;
        output_size          = size;
        operation_mode       = mode;
        for (int c = 0; c < budget && !run_done; c++) begin
            @(negedge clk);
            if (started && !busy && !absorb_enable) begin
                run_done = 1'b1;
            end else begin
                sample_cycle();
                if (absorb_enable) started = 1'b1;
                saw_clr = input_buffer_ready_clr;
                @(posedge clk); #1;
                if (saw_clr) begin
                    blk++;
                    if (blk == nblocks) input_buffer_ready = 1'b0;
                    last_block_in_buffer = (blk == nblocks - 1);
                    // Control inputs must be ignored outside the accept cycle.
                    output_size    = 32'hDEAD_BEEF;
                    operation_mode = ~mode;
                end
            end
        end
        input_buffer_ready = 1'b0;
    endtask

    initial begin
        rst                  = 1'b1;
        input_buffer_ready   = 1'b1;
        last_block_in_buffer = 1'b1;
        output_buffer_ready  = 1'b1;
        output_size          = 32'd256;
        operation_mode       = 2'b00;
        clear_tally();
        run_done = 1'b0;

        // Reset holds every output low even with a block waiting.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", 32'(out_vec()), 32'd0);
        input_buffer_ready = 1'b0;
        rst = 1'b0;

        // SHAKE128, single block, 256-bit output.
        run_msg(2'b00, 32'd256, 1, 200);
        check("s128_256_done",    32'(run_done), 32'd1);
        check("s128_256_absorb",  n_absorb,  1);
        check("s128_256_clear",   n_clear,   1);
        check("s128_256_copy",    n_copy,    1);
        check("s128_256_lastclr", n_lastclr, 1);
        check("s128_256_rounds",  n_round,   24);
        check("s128_256_idx",     idx_err,   0);
        check("s128_256_we",      n_we,      1);
        check("s128_256_cycles",  n_cyc,     26);
        check("s128_256_busy",    32'(busy), 32'd0);

        // Two squeeze blocks: exact multiple and one bit past one block.
        run_msg(2'b00, 32'd2688, 1, 300);
        check("s128_2688_done",   32'(run_done), 32'd1);
        check("s128_2688_we",     n_we,    2);
        check("s128_2688_rounds", n_round, 48);
        run_msg(2'b00, 32'd1345, 1, 300);
        check("s128_1345_done",   32'(run_done), 32'd1);
        check("s128_1345_we",     n_we,    2);
        check("s128_1345_rounds", n_round, 48);
        check("s128_1345_idx",    idx_err, 0);

        // SHAKE256, three-block message.
        run_msg(2'b01, 32'd1088, 3, 400);
        check("s256_1088_done",    32'(run_done), 32'd1);
        check("s256_1088_absorb",  n_absorb,  3);
        check("s256_1088_clear",   n_clear,   1);
        check("s256_1088_lastclr", n_lastclr, 1);
        check("s256_1088_rounds",  n_round,   72);
        check("s256_1088_we",      n_we,      1);
        run_msg(2'b01, 32'd1089, 3, 400);
        check("s256_1089_done",   32'(run_done), 32'd1);
        check("s256_1089_we",     n_we,    2);
        check("s256_1089_rounds", n_round, 96);

        // Reserved mode behaves as SHAKE128: 1345 bits needs two 1344-bit blocks.
        run_msg(2'b11, 32'd1345, 1, 300);
        check("rsv_1345_we", n_we, 2);
        run_msg(2'b11, 32'd1344, 1, 300);
        check("rsv_1344_we", n_we, 1);

        // Zero-length output goes straight back to IDLE.
        run_msg(2'b00, 32'd0, 1, 200);
        check("zero_done",   32'(run_done), 32'd1);
        check("zero_rounds", n_round, 24);
        check("zero_we",     n_we,    0);
        check("zero_cycles", n_cyc,   25);

        // Output buffer stall in SQUEEZE_WAIT.
        clear_tally();
        @(posedge clk); #1;
        input_buffer_ready   = 1'b1;
        last_block_in_buffer = 1'b1;
        output_buffer_ready  = 1'b0;
        output_size          = 32'd256;
        operation_mode       = 2'b00;
        @(negedge clk);
        sample_cycle();
        @(posedge clk); #1;
        input_buffer_ready = 1'b0;
        repeat (24) begin
            @(negedge clk);
            sample_cycle();
        end
        check("stall_rounds", n_round, 24);
        repeat (10) begin
            @(negedge clk);
            sample_cycle();
        end
        check("stall_no_we",     n_we,      0);
        check("stall_no_round",  n_round,   24);
        check("stall_busy",      32'(busy), 32'd1);
        @(posedge clk); #1;
        output_buffer_ready = 1'b1;
        @(negedge clk);
        check("stall_we_after", 32'(output_buffer_we), 32'd1);
        @(negedge clk);
        check("stall_idle", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a permutation.
        @(posedge clk); #1;
        input_buffer_ready   = 1'b1;
        last_block_in_buffer = 1'b1;
        output_size          = 32'd256;
        operation_mode       = 2'b00;
        run_done = 1'b0;
        for (int c = 0; c < 40 && !run_done; c++) begin
            @(negedge clk);
            if (round_en && round_index == 5'd10) run_done = 1'b1;
            else if (busy) input_buffer_ready = 1'b0;
        end
        check("midrst_reached", 32'(run_done), 32'd1);
        input_buffer_ready = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("midrst_outputs", 32'(out_vec()), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_held", 32'(out_vec()), 32'd0);
        input_buffer_ready = 1'b0;
        rst = 1'b0;
        run_msg(2'b00, 32'd256, 1, 200);
        check("postrst_done",   32'(run_done), 32'd1);
        check("postrst_clear",  n_clear, 1);
        check("postrst_rounds", n_round, 24);
        check("postrst_idx",    idx_err, 0);
        check("postrst_we",     n_we,    1);
        check("postrst_cycles", n_cyc,   26);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
